// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and memory stage.
// Memory stage has priority; a starvation counter bounds fetch wait.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req_valid,
  output logic              f_req_ready,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_rsp_valid,
  output logic [DATA_W-1:0] f_rsp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_rw,
  input  logic [1:0]        d_size,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_size,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [SW-1:0] SLIM  = SW'(STARVE_LIMIT);
  localparam logic [CW-1:0] CLOAD = CW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [CW-1:0] lat_cnt;
  logic          win_f;
  logic          win_rw;

  logic window;
  logic starved;
  logic f_pick;
  logic d_pick;
  logic accept;

  always_comb begin
    window  = reset && (state == IDLE || state == RESP);
    starved = (starve_cnt == SLIM);
    f_pick  = f_req_valid && (!d_req_valid || starved);
    d_pick  = d_req_valid && !(f_req_valid && starved);
  end

  assign f_req_ready = window && f_pick;
  assign d_req_ready = window && d_pick;
  assign accept      = f_req_ready || d_req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      lat_cnt     <= '0;
      win_f       <= 1'b0;
      win_rw      <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_size    <= '0;
      mem_wdata   <= '0;
      f_rsp_valid <= 1'b0;
      f_rsp_data  <= '0;
      d_rsp_valid <= 1'b0;
      d_rsp_data  <= '0;
      busy        <= 1'b0;
    end else begin
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      f_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;

      unique case (state)
        IDLE, RESP: begin
          if (accept) begin
            state  <= ISSUE;
            busy   <= 1'b1;
            mem_en <= 1'b1;
            win_f  <= f_req_ready;
            win_rw <= d_req_ready && d_rw;
            mem_we <= d_req_ready && d_rw;
            if (f_req_ready) begin
              mem_addr <= f_addr;
              mem_size <= 2'd2;
            end else begin
              mem_addr  <= d_addr;
              mem_size  <= d_size;
              mem_wdata <= d_wdata;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ISSUE: begin
          state   <= WAIT;
          lat_cnt <= CLOAD;
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            state <= RESP;
            // rdata is valid in the last WAIT cycle only
            if (win_f) begin
              f_rsp_valid <= 1'b1;
              f_rsp_data  <= mem_rdata;
            end else begin
              d_rsp_valid <= 1'b1;
              d_rsp_data  <= win_rw ? '0 : mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (f_req_ready) begin
        starve_cnt <= '0;
      end else if (d_req_ready && f_req_valid && !starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Instance a uses MEM_LATENCY=2, instance b uses MEM_LATENCY=1.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        f_req_valid = 1'b0;
  logic [31:0] f_addr = '0;
  logic        d_req_valid = 1'b0;
  logic [31:0] d_addr = '0;
  logic        d_rw = 1'b0;
  logic [1:0]  d_size = 2'd2;
  logic [31:0] d_wdata = '0;

  logic        f_rdy_a, f_rv_a, d_rdy_a, d_rv_a;
  logic        en_a, we_a, busy_a;
  logic [31:0] f_rd_a, d_rd_a, addr_a, wd_a, rdata_a;
  logic [1:0]  size_a;

  logic        f_rdy_b, f_rv_b, d_rdy_b, d_rv_b;
  logic        en_b, we_b, busy_b;
  logic [31:0] f_rd_b, d_rd_b, addr_b, wd_b, rdata_b;
  logic [1:0]  size_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)
  ) dut_a (
    .clk(clk), .reset(reset),
    .f_req_valid(f_req_valid), .f_req_ready(f_rdy_a), .f_addr(f_addr),
    .f_rsp_valid(f_rv_a), .f_rsp_data(f_rd_a),
    .d_req_valid(d_req_valid), .d_req_ready(d_rdy_a), .d_addr(d_addr),
    .d_rw(d_rw), .d_size(d_size), .d_wdata(d_wdata),
    .d_rsp_valid(d_rv_a), .d_rsp_data(d_rd_a),
    .mem_en(en_a), .mem_we(we_a), .mem_addr(addr_a), .mem_size(size_a),
    .mem_wdata(wd_a), .mem_rdata(rdata_a), .busy(busy_a)
  );

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)
  ) dut_b (
    .clk(clk), .reset(reset),
    .f_req_valid(f_req_valid), .f_req_ready(f_rdy_b), .f_addr(f_addr),
    .f_rsp_valid(f_rv_b), .f_rsp_data(f_rd_b),
    .d_req_valid(d_req_valid), .d_req_ready(d_rdy_b), .d_addr(d_addr),
    .d_rw(d_rw), .d_size(d_size), .d_wdata(d_wdata),
    .d_rsp_valid(d_rv_b), .d_rsp_data(d_rd_b),
    .mem_en(en_b), .mem_we(we_b), .mem_addr(addr_b), .mem_size(size_b),
    .mem_wdata(wd_b), .mem_rdata(rdata_b), .busy(busy_b)
  );

  function automatic logic [31:0] mem_lookup(input logic [31:0] a);
    if (a == 32'h0100_0000) return 32'h0000_0013;
    if (a == 32'h0100_0200) return 32'hCAFE_F00D;
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // Memory models: data valid only in cycle mem_en + latency
  logic [1:0]  en_a_d = '0;
  logic [31:0] ad_a_d0 = '0, ad_a_d1 = '0;
  logic        en_b_d = 1'b0;
  logic [31:0] ad_b_d = '0;

  always @(posedge clk) begin
    en_a_d  <= {en_a_d[0], en_a};
    ad_a_d1 <= ad_a_d0;
    ad_a_d0 <= addr_a;
    en_b_d  <= en_b;
    ad_b_d  <= addr_b;
  end

  assign rdata_a = en_a_d[1] ? mem_lookup(ad_a_d1) : 32'hBAD0_BAD0;
  assign rdata_b = en_b_d ? mem_lookup(ad_b_d) : 32'hBAD0_BAD0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    f_req_valid = 1'b0;
    d_req_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    f_req_valid = 1'b1;
    d_req_valid = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({en_a, we_a, f_rv_a, d_rv_a, busy_a, f_rdy_a, d_rdy_a} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctl_a: got %b want 0",
        {en_a, we_a, f_rv_a, d_rv_a, busy_a, f_rdy_a, d_rdy_a});
    end
    checks++;
    if ({addr_a, wd_a, size_a, f_rd_a, d_rd_a} !== '0) begin
      failures++;
      $display("FAIL reset_data_a: got %h want 0",
        {addr_a, wd_a, size_a, f_rd_a, d_rd_a});
    end
    checks++;
    if ({en_b, we_b, f_rv_b, d_rv_b, busy_b, f_rdy_b, d_rdy_b} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctl_b: got %b want 0",
        {en_b, we_b, f_rv_b, d_rv_b, busy_b, f_rdy_b, d_rdy_b});
    end
    f_req_valid = 1'b0;
    d_req_valid = 1'b0;
    #1 reset = 1'b1;
    tick();
  endtask

  task automatic test_fetch_read();
    f_req_valid = 1'b1;
    f_addr = 32'h0100_0000;
    #1;
    checks++;
    if ({f_rdy_a, d_rdy_a} !== 2'b10) begin
      failures++;
      $display("FAIL fr_ready: got %b want 10", {f_rdy_a, d_rdy_a});
    end
    tick();
    f_req_valid = 1'b0;
    #1;
    checks++;
    if ({en_a, we_a, size_a, busy_a} !== 5'b10_10_1) begin
      failures++;
      $display("FAIL fr_issue: got %b want 10101", {en_a, we_a, size_a, busy_a});
    end
    checks++;
    if (addr_a !== 32'h0100_0000) begin
      failures++;
      $display("FAIL fr_addr: got %h want 01000000", addr_a);
    end
    tick();
    checks++;
    if ({en_a, busy_a} !== 2'b01) begin
      failures++;
      $display("FAIL fr_c2: got %b want 01", {en_a, busy_a});
    end
    tick();
    checks++;
    if ({busy_a, f_rv_a} !== 2'b10) begin
      failures++;
      $display("FAIL fr_c3: got %b want 10", {busy_a, f_rv_a});
    end
    tick();
    checks++;
    if ({f_rv_a, d_rv_a, f_rd_a} !== {2'b10, 32'h0000_0013}) begin
      failures++;
      $display("FAIL fr_rsp: got %b %h want 10 00000013", {f_rv_a, d_rv_a}, f_rd_a);
    end
    tick();
    checks++;
    if ({f_rv_a, busy_a} !== 2'b00) begin
      failures++;
      $display("FAIL fr_done: got %b want 00", {f_rv_a, busy_a});
    end
    idle(4);
  endtask

  task automatic test_simultaneous();
    f_req_valid = 1'b1;
    f_addr = 32'h0100_0000;
    d_req_valid = 1'b1;
    d_addr = 32'h0100_0100;
    d_rw = 1'b1;
    d_size = 2'd2;
    d_wdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({f_rdy_a, d_rdy_a} !== 2'b01) begin
      failures++;
      $display("FAIL sim_grant: got %b want 01", {f_rdy_a, d_rdy_a});
    end
    tick();
    d_req_valid = 1'b0;
    d_rw = 1'b0;
    #1;
    checks++;
    if ({en_a, we_a, size_a, f_rdy_a} !== 5'b11_10_0) begin
      failures++;
      $display("FAIL sim_issue: got %b want 11100", {en_a, we_a, size_a, f_rdy_a});
    end
    checks++;
    if ({addr_a, wd_a} !== {32'h0100_0100, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL sim_payload: got %h %h want 01000100 deadbeef", addr_a, wd_a);
    end
    tick();
    tick();
    checks++;
    if (f_rdy_a !== 1'b0) begin
      failures++;
      $display("FAIL sim_hold: got %b want 0", f_rdy_a);
    end
    tick();
    checks++;
    if ({d_rv_a, d_rd_a, f_rdy_a} !== {1'b1, 32'h0, 1'b1}) begin
      failures++;
      $display("FAIL sim_resp: got %b %h %b want 1 00000000 1", d_rv_a, d_rd_a, f_rdy_a);
    end
    tick();
    f_req_valid = 1'b0;
    #1;
    checks++;
    if ({en_a, we_a, addr_a} !== {2'b10, 32'h0100_0000}) begin
      failures++;
      $display("FAIL sim_fetch_issue: got %b %h want 10 01000000", {en_a, we_a}, addr_a);
    end
    repeat (3) tick();
    checks++;
    if ({f_rv_a, f_rd_a} !== {1'b1, 32'h0000_0013}) begin
      failures++;
      $display("FAIL sim_fetch_rsp: got %b %h want 1 00000013", f_rv_a, f_rd_a);
    end
    idle(4);
  endtask

  task automatic test_starvation();
    logic [7:0] got [6];
    logic [7:0] exp_g [6];
    int n;
    int viol;
    logic prev_en;
    logic chk_zero;
    exp_g = '{"D", "D", "D", "D", "F", "D"};
    n = 0;
    viol = 0;
    prev_en = 1'b0;
    chk_zero = 1'b0;
    f_req_valid = 1'b1;
    f_addr = 32'h0100_0000;
    d_req_valid = 1'b1;
    d_addr = 32'h0100_0400;
    d_rw = 1'b0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      #1;
      if (en_a && prev_en) viol++;
      if (f_rv_a && d_rv_a) viol++;
      prev_en = en_a;
      if (chk_zero) begin
        chk_zero = 1'b0;
        checks++;
        if (dut_a.starve_cnt !== 3'd0) begin
          failures++;
          $display("FAIL starve_clear: got %0d want 0", dut_a.starve_cnt);
        end
      end
      if (d_rdy_a) begin
        got[n] = "D";
        n++;
      end else if (f_rdy_a) begin
        checks++;
        if (dut_a.starve_cnt !== 3'd4) begin
          failures++;
          $display("FAIL starve_full: got %0d want 4", dut_a.starve_cnt);
        end
        got[n] = "F";
        n++;
        chk_zero = 1'b1;
      end
      tick();
    end
    checks++;
    if (n != 6) begin
      failures++;
      $display("FAIL starve_timeout: got %0d grants want 6", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got[i] !== exp_g[i]) begin
        failures++;
        $display("FAIL starve_grant%0d: got %c want %c", i, got[i], exp_g[i]);
      end
    end
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL starve_proto: got %0d violations want 0", viol);
    end
    idle(8);
  endtask

  task automatic test_back_to_back();
    int acc [$];
    int ens;
    ens = 0;
    f_addr = 32'h0100_0000;
    for (int i = 0; i < 12; i++) begin
      f_req_valid = (i <= 8);
      #1;
      if (f_rdy_a) acc.push_back(i);
      if (en_a) ens++;
      tick();
    end
    checks++;
    if (acc.size() != 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d want 3", acc.size());
    end else begin
      checks++;
      if (acc[0] != 0 || acc[1] != 4 || acc[2] != 8) begin
        failures++;
        $display("FAIL b2b_cycles: got %0d %0d %0d want 0 4 8", acc[0], acc[1], acc[2]);
      end
    end
    checks++;
    if (ens != 3) begin
      failures++;
      $display("FAIL b2b_mem_en: got %0d want 3", ens);
    end
    idle(6);
  endtask

  task automatic test_reset_mid();
    int frsp;
    int drsp_at;
    frsp = 0;
    drsp_at = -1;
    f_req_valid = 1'b1;
    f_addr = 32'h0100_0000;
    tick();
    f_req_valid = 1'b0;
    tick();
    #1 reset = 1'b0;
    d_req_valid = 1'b1;
    d_addr = 32'h0100_0300;
    d_rw = 1'b0;
    #1;
    checks++;
    if ({en_a, f_rv_a, d_rv_a, busy_a, f_rdy_a, d_rdy_a, addr_a, size_a} !== '0) begin
      failures++;
      $display("FAIL rmid_zero: got %b %h want 0",
        {en_a, f_rv_a, d_rv_a, busy_a, f_rdy_a, d_rdy_a}, addr_a);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (d_rdy_a !== 1'b1) begin
      failures++;
      $display("FAIL rmid_accept: got %b want 1", d_rdy_a);
    end
    tick();
    d_req_valid = 1'b0;
    #1;
    checks++;
    if ({en_a, addr_a} !== {1'b1, 32'h0100_0300}) begin
      failures++;
      $display("FAIL rmid_issue: got %b %h want 1 01000300", en_a, addr_a);
    end
    for (int k = 2; k < 9; k++) begin
      tick();
      if (f_rv_a) frsp++;
      if (d_rv_a) begin
        drsp_at = k;
        checks++;
        if (d_rd_a !== 32'h5B5A_595A) begin
          failures++;
          $display("FAIL rmid_data: got %h want 5b5a595a", d_rd_a);
        end
      end
    end
    checks++;
    if (frsp != 0) begin
      failures++;
      $display("FAIL rmid_dropped: got %0d fetch rsp want 0", frsp);
    end
    checks++;
    if (drsp_at != 4) begin
      failures++;
      $display("FAIL rmid_rsp_cycle: got %0d want 4", drsp_at);
    end
    idle(8);
  endtask

  task automatic test_min_latency();
    int acc [$];
    d_req_valid = 1'b1;
    d_addr = 32'h0100_0200;
    d_rw = 1'b0;
    d_size = 2'd2;
    #1;
    checks++;
    if (d_rdy_b !== 1'b1) begin
      failures++;
      $display("FAIL ml_ready: got %b want 1", d_rdy_b);
    end
    tick();
    d_req_valid = 1'b0;
    #1;
    checks++;
    if ({en_b, we_b, addr_b} !== {2'b10, 32'h0100_0200}) begin
      failures++;
      $display("FAIL ml_issue: got %b %h want 10 01000200", {en_b, we_b}, addr_b);
    end
    tick();
    checks++;
    if (d_rv_b !== 1'b0) begin
      failures++;
      $display("FAIL ml_early: got %b want 0", d_rv_b);
    end
    tick();
    checks++;
    if ({d_rv_b, d_rd_b} !== {1'b1, 32'hCAFE_F00D}) begin
      failures++;
      $display("FAIL ml_rsp: got %b %h want 1 cafef00d", d_rv_b, d_rd_b);
    end
    idle(6);
    for (int i = 0; i < 9; i++) begin
      d_req_valid = (i <= 6);
      #1;
      if (d_rdy_b) acc.push_back(i);
      tick();
    end
    checks++;
    if (acc.size() != 3) begin
      failures++;
      $display("FAIL ml_b2b_count: got %0d want 3", acc.size());
    end else begin
      checks++;
      if (acc[0] != 0 || acc[1] != 3 || acc[2] != 6) begin
        failures++;
        $display("FAIL ml_b2b_cycles: got %0d %0d %0d want 0 3 6", acc[0], acc[1], acc[2]);
      end
    end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_simultaneous();
    test_starvation();
    test_back_to_back();
    test_reset_mid();
    test_min_latency();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported unified instruction/data memory between the fetch stage and the memory stage of the five-stage RISC-V pipeline. Each request is accepted through a valid/ready handshake and issued to the memory as a one-cycle strobe. The arbiter waits the memory's fixed read latency and then returns a one-cycle response to the requester that won. The memory stage has priority; a starvation counter guarantees fetch forward progress.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LATENCY`, 2, cycles from `mem_en` to valid `mem_rdata`; must be >= 1
- `STARVE_LIMIT`, 4, consecutive fetch losses before fetch is forced to win; must be >= 1

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `f_req_valid`  in  1  fetch read request
- `f_req_ready`  out  1  fetch request accepted this cycle
- `f_addr`  in  ADDR_W  fetch address
- `f_rsp_valid`  out  1  fetch response strobe
- `f_rsp_data`  out  DATA_W  fetched instruction
- `d_req_valid`  in  1  memory-stage request
- `d_req_ready`  out  1  memory-stage request accepted this cycle
- `d_addr`  in  ADDR_W  data address
- `d_rw`  in  1  1 = write, 0 = read
- `d_size`  in  2  0 byte, 1 half, 2 word, 3 treated as word
- `d_wdata`  in  DATA_W  store data
- `d_rsp_valid`  out  1  data response strobe (read data or write acknowledge)
- `d_rsp_data`  out  DATA_W  load data; 0 for writes
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  write enable, qualified by `mem_en`
- `mem_addr`  out  ADDR_W  access address
- `mem_size`  out  2  access size; always 2 for fetch
- `mem_wdata`  out  DATA_W  store data
- `mem_rdata`  in  DATA_W  read data
- `busy`  out  1  a transaction is in flight (state is not IDLE)

## Operation
- FSM states:
  - IDLE: no transaction.
  - ISSUE: `mem_en`=1 for exactly one cycle; address, write enable, size and write data come from registers latched at accept.
  - WAIT: lasts `MEM_LATENCY` cycles; a down-counter is loaded with `MEM_LATENCY`-1.
  - RESP: the winner's `*_rsp_valid`=1 for one cycle.
- Transitions: IDLE→ISSUE on accept, ISSUE→WAIT, WAIT→RESP when the counter reaches 0, RESP→ISSUE on accept, otherwise RESP→IDLE.
- Grant window: requests are accepted only in IDLE or RESP.
- Ready outputs: `*_req_ready` is combinational and asserted only for the winner, only when that requester is valid, and only in the grant window.
  - A handshake is valid & ready in the same cycle.
  - The requester holds valid and its payload until accepted.
- Arbitration when both requesters are valid:
  - Data wins unless `starve_cnt` == `STARVE_LIMIT`; then fetch wins.
  - A lone valid requester always wins.
- Starvation counter `starve_cnt` (width clog2(`STARVE_LIMIT`+1)):
  - +1, saturating, when data is granted while `f_req_valid`=1.
  - Cleared to 0 when fetch is granted.
  - Unchanged otherwise.
- Read data capture: `mem_rdata` is captured into the response register at the end of the last WAIT cycle and is driven on `*_rsp_data` during RESP.
  - Writes drive `d_rsp_data`=0.
  - The non-winning response data output holds its previous value.
- Size and alignment: no alignment checking; address and size pass through unchanged.
- Reset (asynchronous, any state including mid-transaction):
  - State → IDLE, counters → 0.
  - In-flight transaction is dropped; no response is ever produced for it.
  - All registered outputs → 0.
  - Ready outputs are forced to 0 while `reset`=0.

## Timing
- Accept in cycle 0:
  - `mem_en` in cycle 1.
  - `mem_rdata` valid in cycle 1+`MEM_LATENCY`.
  - `*_rsp_valid` in cycle 2+`MEM_LATENCY`.
- Back-to-back throughput: one transaction per `MEM_LATENCY`+2 cycles, because a new accept is allowed in the RESP cycle.
- Output values while in reset: `mem_en`, `mem_we`, `f_rsp_valid`, `d_rsp_valid`, `busy`, `f_req_ready`, `d_req_ready` = 0; `mem_addr`, `mem_wdata`, `mem_size`, `f_rsp_data`, `d_rsp_data` = 0.
- `mem_en` is never high in two consecutive cycles.
- `f_rsp_valid` and `d_rsp_valid` are never high in the same cycle.

## Test plan
- **Fetch read:** `MEM_LATENCY`=2; fetch-only read at 0x01000000; memory returns 0x00000013 in cycle 3 → `f_req_ready` in cycle 0, `mem_en`=1 with `mem_size`=2 in cycle 1, `f_rsp_valid`=1 with data 0x00000013 in cycle 4, `busy` high in cycles 1–3.
- **Simultaneous requests:** fetch 0x01000000 and data write 0x01000100 / 0xDEADBEEF / size 2 in cycle 0 → data granted, `mem_we`=1 in cycle 1, `d_rsp_valid`=1 with data 0 in cycle 4, fetch accepted in cycle 4, `mem_en` for fetch in cycle 5.
- **Starvation:** both requesters held valid continuously, `STARVE_LIMIT`=4 → grants go D, D, D, D, F, D, …; `starve_cnt` is 0 after the fetch grant.
- **Back-to-back fetch:** fetch held valid → accepts in cycles 0, 4, 8; exactly one `mem_en` per transaction.
- **Reset mid-transaction:** `reset` pulled low during WAIT → all outputs 0 immediately, no `*_rsp_valid` afterward; after release with `d_req_valid`=1, accept occurs in the first cycle out of reset.
- **Minimum latency:** `MEM_LATENCY`=1 with a data read of 0x01000200 returning 0xCAFEF00D → `d_rsp_valid`=1 with 0xCAFEF00D in cycle 3; back-to-back accepts every 3 cycles.
